// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, packed bus layouts,
// load-type codes and exception codes.
package mem_stage_pkg;

  localparam int EX_MEM_BUS_W = 240;
  localparam int MEM_WB_BUS_W = 204;

  // Load/store width codes carried in the EX->MEM bus; 5-7 behave as MT_W.
  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_H  = 3'd1;
  localparam logic [2:0] MT_W  = 3'd2;
  localparam logic [2:0] MT_BU = 3'd3;
  localparam logic [2:0] MT_HU = 3'd4;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  // MEM->WB payload, MSB first (204 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        gr_we;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic        ex;
    logic        ertn;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] badv;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [3:0]  rdcnt_op;
  } mem_wb_t;

  // EX->MEM payload: the WB fields plus the MEM-only load controls,
  // padded with a spare field up to the shared bus width (240 bits).
  typedef struct packed {
    mem_wb_t     wb;
    logic [2:0]  mem_type;
    logic [1:0]  addr_low2;
    logic [30:0] rsvd;
  } ex_mem_t;

  // Field offsets (LSB positions) within the flat buses.
  localparam int EM_RSVD_LSB      = 0;
  localparam int EM_ADDR_LOW2_LSB = 31;
  localparam int EM_MEM_TYPE_LSB  = 33;
  localparam int EM_WB_LSB        = 36;
  localparam int WB_RDCNT_LSB     = 0;
  localparam int WB_CSR_WDATA_LSB = 4;
  localparam int WB_CSR_WMASK_LSB = 36;
  localparam int WB_CSR_NUM_LSB   = 68;
  localparam int WB_CSR_RE_LSB    = 82;
  localparam int WB_CSR_WE_LSB    = 83;
  localparam int WB_BADV_LSB      = 84;
  localparam int WB_ESUBCODE_LSB  = 116;
  localparam int WB_ECODE_LSB     = 125;
  localparam int WB_ERTN_LSB      = 131;
  localparam int WB_EX_LSB        = 132;
  localparam int WB_RES_MEM_LSB   = 133;
  localparam int WB_DEST_LSB      = 134;
  localparam int WB_GR_WE_LSB     = 139;
  localparam int WB_RESULT_LSB    = 140;
  localparam int WB_PC_LSB        = 172;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data alignment: picks the addressed byte/half of the
// read word and sign- or zero-extends it according to the load type.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_low2,
  input  logic [2:0]  mem_type,
  output logic [31:0] value
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    value    = rdata;
    shifted  = rdata >> {addr_low2, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_low2[1] ? rdata[31:16] : rdata[15:0];
    case (mem_type)
      MT_B:    value = {{24{byte_sel[7]}}, byte_sel};
      MT_H:    value = {{16{half_sel[15]}}, half_sel};
      MT_BU:   value = {24'd0, byte_sel};
      MT_HU:   value = {16'd0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the EX->MEM payload, waits for the data
// SRAM response, aligns load data and hands the result to WB.
module mem_stage #(
  parameter int EX_MEM_BUS_W = mem_stage_pkg::EX_MEM_BUS_W,
  parameter int MEM_WB_BUS_W = mem_stage_pkg::MEM_WB_BUS_W,
  parameter int CANCEL_CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_mem_valid,
  input  logic [EX_MEM_BUS_W-1:0] ex_mem_bus,
  input  logic                    ex_mem_req,
  output logic                    mem_allowin,
  input  logic                    wb_allowin,
  output logic                    mem_wb_valid,
  output logic [MEM_WB_BUS_W-1:0] mem_wb_bus,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    wb_ex,
  input  logic                    ertn_flush,
  output logic                    mem_ex,
  output logic                    mem_ertn,
  output logic [38:0]             mem_id_bus
);
  import mem_stage_pkg::*;

  localparam logic [CANCEL_CNT_W-1:0] CNT_MAX = '1;

  logic                    mem_valid;
  logic                    req_pend;
  logic                    buf_valid;
  logic [31:0]             buf_data;
  logic [CANCEL_CNT_W-1:0] cancel_cnt;
  ex_mem_t                 bus_q;

  logic        flush;
  logic        hit;
  logic        mem_ready_go;
  logic        handoff;
  logic        cancel_inc;
  logic        cancel_dec;
  logic [31:0] rdata_sel;
  logic [31:0] load_val;
  logic [31:0] final_result;
  logic        mem_bypass;
  logic        mem_ld_wait;
  mem_wb_t     wb_out;

  assign flush        = wb_ex | ertn_flush;
  assign hit          = data_sram_data_ok & (cancel_cnt == '0);
  assign mem_ready_go = ~req_pend | hit | buf_valid;
  assign mem_wb_valid = mem_valid & mem_ready_go;
  assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);
  assign handoff      = mem_wb_valid & wb_allowin;

  // A response is owed but will never be consumed: either the flushed
  // instruction was still waiting, or EX issued a request in the flush cycle.
  assign cancel_inc = flush & ((mem_valid & req_pend & ~hit & ~buf_valid)
                             | (ex_mem_valid & ex_mem_req & mem_allowin));
  assign cancel_dec = data_sram_data_ok & (cancel_cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid <= 1'b0;
      req_pend  <= 1'b0;
    end else if (flush) begin
      mem_valid <= 1'b0;
      req_pend  <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid <= ex_mem_valid;
      req_pend  <= ex_mem_valid & ex_mem_req;
    end
  end

  // NOTE: the payload register is reset too, so every bus output reads zero
  // out of reset rather than X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q <= '0;
    end else if (mem_allowin & ~flush & ex_mem_valid) begin
      bus_q <= ex_mem_t'(ex_mem_bus);
    end
  end

  // Holds a response that arrived while WB was stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= 32'd0;
    end else if (flush | handoff) begin
      buf_valid <= 1'b0;
    end else if (hit & ~wb_allowin & mem_valid) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cancel_cnt <= '0;
    end else begin
      case ({cancel_inc, cancel_dec})
        2'b10: if (cancel_cnt != CNT_MAX) cancel_cnt <= cancel_cnt + 1'b1;
        2'b01: cancel_cnt <= cancel_cnt - 1'b1;
        default: cancel_cnt <= cancel_cnt;
      endcase
    end
  end

  assign rdata_sel = buf_valid ? buf_data : data_sram_rdata;

  mem_load_align u_align (
    .rdata     (rdata_sel),
    .addr_low2 (bus_q.addr_low2),
    .mem_type  (bus_q.mem_type),
    .value     (load_val)
  );

  assign final_result = bus_q.wb.res_from_mem ? load_val : bus_q.wb.result;

  always_comb begin
    wb_out        = bus_q.wb;
    wb_out.result = final_result;
  end

  assign mem_wb_bus  = wb_out;
  assign mem_ex      = mem_valid & bus_q.wb.ex;
  assign mem_ertn    = mem_valid & bus_q.wb.ertn;
  assign mem_bypass  = mem_valid & bus_q.wb.gr_we & ~bus_q.wb.ex;
  assign mem_ld_wait = mem_valid & bus_q.wb.res_from_mem & ~mem_ready_go;
  assign mem_id_bus  = {mem_bypass, mem_ld_wait, bus_q.wb.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: a table of single-instruction
// vectors plus hand-written multi-cycle sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ex_mem_valid;
  logic [239:0] ex_mem_bus;
  logic         ex_mem_req;
  logic         mem_allowin;
  logic         wb_allowin;
  logic         mem_wb_valid;
  logic [203:0] mem_wb_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         wb_ex;
  logic         ertn_flush;
  logic         mem_ex;
  logic         mem_ertn;
  logic [38:0]  mem_id_bus;

  mem_wb_t wb_view;
  assign wb_view = mem_wb_bus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_bus        (ex_mem_bus),
    .ex_mem_req        (ex_mem_req),
    .mem_allowin       (mem_allowin),
    .wb_allowin        (wb_allowin),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_bus        (mem_wb_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .mem_ex            (mem_ex),
    .mem_ertn          (mem_ertn),
    .mem_id_bus        (mem_id_bus)
  );

  typedef struct {
    logic [2:0]  mt;
    logic [1:0]  al;
    logic        rfm;
    logic        req;
    logic [31:0] rdata;
    logic [31:0] ex_res;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_mem_t make_bus(input logic [2:0] mt, input logic [1:0] al,
                                       input logic rfm, input logic gr_we,
                                       input logic [31:0] res, input logic [4:0] dest,
                                       input logic ex, input logic ertn,
                                       input logic [5:0] ecode);
    ex_mem_t b;
    b                  = '0;
    b.wb.pc            = 32'h1C00_0000 | {25'd0, dest, 2'b00};
    b.wb.result        = res;
    b.wb.gr_we         = gr_we;
    b.wb.dest          = dest;
    b.wb.res_from_mem  = rfm;
    b.wb.ex            = ex;
    b.wb.ertn          = ertn;
    b.wb.ecode         = ecode;
    b.wb.badv          = ex ? res : 32'd0;
    b.wb.csr_num       = 14'h0005;
    b.wb.csr_wmask     = 32'h0000_FFFF;
    b.wb.csr_wdata     = 32'hA5A5_0000 | {27'd0, dest};
    b.wb.rdcnt_op      = 4'h3;
    b.mem_type         = mt;
    b.addr_low2        = al;
    b.rsvd             = 31'h1234_5678;
    return b;
  endfunction

  function automatic mem_wb_t exp_wb(input ex_mem_t b, input logic [31:0] r);
    mem_wb_t w;
    w        = b.wb;
    w.result = r;
    return w;
  endfunction

  task automatic enter(input ex_mem_t b, input logic req);
    ex_mem_valid = 1'b1;
    ex_mem_bus   = b;
    ex_mem_req   = req;
  endtask

  task automatic clear_ex();
    ex_mem_valid = 1'b0;
    ex_mem_req   = 1'b0;
    ex_mem_bus   = '0;
  endtask

  initial begin
    ex_mem_t b;
    logic    byp;

    clear_ex();
    wb_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h5555_5555;
    wb_ex             = 1'b0;
    ertn_flush        = 1'b0;

    vecs[0]  = '{MT_B,  2'd3, 1'b1, 1'b1, 32'h80FF_FF7F, 32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{MT_B,  2'd0, 1'b1, 1'b1, 32'h80FF_FF7F, 32'h0,         32'h0000_007F};
    vecs[2]  = '{MT_B,  2'd1, 1'b1, 1'b1, 32'h0000_8000, 32'h0,         32'hFFFF_FF80};
    vecs[3]  = '{MT_BU, 2'd2, 1'b1, 1'b1, 32'h12C3_56A5, 32'h0,         32'h0000_00C3};
    vecs[4]  = '{MT_H,  2'd2, 1'b1, 1'b1, 32'h9ABC_1234, 32'h0,         32'hFFFF_9ABC};
    vecs[5]  = '{MT_H,  2'd0, 1'b1, 1'b1, 32'h9ABC_8001, 32'h0,         32'hFFFF_8001};
    vecs[6]  = '{MT_HU, 2'd2, 1'b1, 1'b1, 32'h9ABC_1234, 32'h0,         32'h0000_9ABC};
    vecs[7]  = '{MT_W,  2'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
    vecs[8]  = '{3'd6,  2'd0, 1'b1, 1'b1, 32'h0102_0304, 32'h0,         32'h0102_0304};
    vecs[9]  = '{MT_B,  2'd0, 1'b0, 1'b0, 32'h0,         32'h0000_1234, 32'h0000_1234};
    vecs[10] = '{MT_W,  2'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1000_0040, 32'h1000_0040};
    vecs[11] = '{MT_HU, 2'd0, 1'b1, 1'b1, 32'h0000_F00F, 32'h0,         32'h0000_F00F};

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_wb_valid", mem_wb_valid, 1'b0);
    check("rst_wb_bus",   mem_wb_bus,   204'd0);
    check("rst_id_bus",   mem_id_bus,   39'd0);
    check("rst_ex_ertn",  {mem_ex, mem_ertn}, 2'b00);
    check("rst_allowin",  mem_allowin,  1'b1);
    step();
    reset = 1'b0;

    // Table-driven single-instruction vectors
    for (int i = 0; i < 12; i++) begin
      byp = vecs[i].rfm | ~vecs[i].req;
      b   = make_bus(vecs[i].mt, vecs[i].al, vecs[i].rfm, byp, vecs[i].ex_res,
                     5'(i + 1), 1'b0, 1'b0, ECODE_INT);
      enter(b, vecs[i].req);
      #1;
      check($sformatf("v%0d_allowin", i), mem_allowin, 1'b1);
      step();
      clear_ex();
      if (vecs[i].req) begin
        #1;
        check($sformatf("v%0d_wait_valid", i), mem_wb_valid, 1'b0);
        check($sformatf("v%0d_wait_ldw", i), mem_id_bus[37], vecs[i].rfm);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = vecs[i].rdata;
      end
      #1;
      check($sformatf("v%0d_valid", i), mem_wb_valid, 1'b1);
      check($sformatf("v%0d_result", i), wb_view.result, vecs[i].exp);
      check($sformatf("v%0d_wb_bus", i), mem_wb_bus, exp_wb(b, vecs[i].exp));
      check($sformatf("v%0d_id_bus", i), mem_id_bus,
            {byp, 1'b0, 5'(i + 1), vecs[i].exp});
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h5555_5555;
      #1;
      check($sformatf("v%0d_gone", i), mem_wb_valid, 1'b0);
    end

    // Response arrives while WB stalls: buffered, delivered when WB opens
    b = make_bus(MT_HU, 2'd2, 1'b1, 1'b1, 32'h0, 5'd20, 1'b0, 1'b0, ECODE_INT);
    enter(b, 1'b1);
    step();
    clear_ex();
    wb_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h9ABC_1234;
    #1;
    check("buf_dok_valid",   mem_wb_valid, 1'b1);
    check("buf_dok_allowin", mem_allowin,  1'b0);
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h5555_5555;
    #1;
    check("buf_hold1_allowin", mem_allowin,    1'b0);
    check("buf_hold1_result",  wb_view.result, 32'h0000_9ABC);
    step();
    #1;
    check("buf_hold2_allowin", mem_allowin,    1'b0);
    check("buf_hold2_valid",   mem_wb_valid,   1'b1);
    step();
    wb_allowin = 1'b1;
    #1;
    check("buf_rel_allowin", mem_allowin,    1'b1);
    check("buf_rel_result",  wb_view.result, 32'h0000_9ABC);
    step();
    #1;
    check("buf_gone", mem_wb_valid, 1'b0);

    // Flush while a load waits: its late response must be dropped
    b = make_bus(MT_W, 2'd0, 1'b1, 1'b1, 32'h0, 5'd7, 1'b0, 1'b0, ECODE_INT);
    enter(b, 1'b1);
    step();
    clear_ex();
    #1;
    check("fl_wait_ldw", mem_id_bus[37], 1'b1);
    wb_ex = 1'b1;
    step();
    wb_ex = 1'b0;
    #1;
    check("fl_valid",  mem_wb_valid,       1'b0);
    check("fl_id_flg", mem_id_bus[38:37],  2'b00);
    b = make_bus(MT_W, 2'd0, 1'b1, 1'b1, 32'h0, 5'd8, 1'b0, 1'b0, ECODE_INT);
    enter(b, 1'b1);
    step();
    clear_ex();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_0BAD;
    #1;
    check("fl_stale_valid", mem_wb_valid,   1'b0);
    check("fl_stale_ldw",   mem_id_bus[37], 1'b1);
    step();
    data_sram_data_ok = 1'b0;
    #1;
    check("fl_gap_valid", mem_wb_valid, 1'b0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h600D_F00D;
    #1;
    check("fl_new_valid",  mem_wb_valid,   1'b1);
    check("fl_new_result", wb_view.result, 32'h600D_F00D);
    step();
    data_sram_data_ok = 1'b0;

    // Flush in the very cycle EX hands over an issued request
    b = make_bus(MT_B, 2'd0, 1'b1, 1'b1, 32'h0, 5'd10, 1'b0, 1'b0, ECODE_INT);
    enter(b, 1'b1);
    ertn_flush = 1'b1;
    step();
    clear_ex();
    ertn_flush = 1'b0;
    #1;
    check("efl_valid", mem_wb_valid,   1'b0);
    check("efl_ldw",   mem_id_bus[37], 1'b0);
    b = make_bus(MT_BU, 2'd1, 1'b1, 1'b1, 32'h0, 5'd11, 1'b0, 1'b0, ECODE_INT);
    enter(b, 1'b1);
    step();
    clear_ex();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_7700;
    #1;
    check("efl_stale_valid", mem_wb_valid, 1'b0);
    step();
    data_sram_rdata = 32'h0000_A500;
    #1;
    check("efl_new_valid",  mem_wb_valid,   1'b1);
    check("efl_new_result", wb_view.result, 32'h0000_00A5);
    step();
    data_sram_data_ok = 1'b0;

    // Excepting load: no request, immediate handoff, no bypass
    b = make_bus(MT_W, 2'd1, 1'b1, 1'b1, 32'h0000_1001, 5'd9, 1'b1, 1'b0, ECODE_ALE);
    enter(b, 1'b0);
    step();
    clear_ex();
    #1;
    check("exc_mem_ex",  mem_ex,          1'b1);
    check("exc_bypass",  mem_id_bus[38],  1'b0);
    check("exc_ldw",     mem_id_bus[37],  1'b0);
    check("exc_valid",   mem_wb_valid,    1'b1);
    check("exc_ecode",   wb_view.ecode,   ECODE_ALE);
    step();
    #1;
    check("exc_gone", mem_ex, 1'b0);

    // ertn instruction
    b = make_bus(MT_B, 2'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, ECODE_INT);
    enter(b, 1'b0);
    step();
    clear_ex();
    #1;
    check("ertn_flag",  mem_ertn,     1'b1);
    check("ertn_valid", mem_wb_valid, 1'b1);
    step();

    // Asynchronous reset mid-request, then a clean load
    b = make_bus(MT_W, 2'd0, 1'b1, 1'b1, 32'h0, 5'd12, 1'b0, 1'b0, ECODE_INT);
    enter(b, 1'b1);
    step();
    clear_ex();
    #1;
    check("arst_pre_ldw", mem_id_bus[37], 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid",   mem_wb_valid, 1'b0);
    check("arst_id_bus",  mem_id_bus,   39'd0);
    check("arst_wb_bus",  mem_wb_bus,   204'd0);
    check("arst_allowin", mem_allowin,  1'b1);
    #2 reset = 1'b0;
    b = make_bus(MT_H, 2'd2, 1'b1, 1'b1, 32'h0, 5'd13, 1'b0, 1'b0, ECODE_INT);
    enter(b, 1'b1);
    step();
    clear_ex();
    #1;
    check("post_wait", mem_wb_valid, 1'b0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h7FFF_0000;
    #1;
    check("post_valid",  mem_wb_valid,   1'b1);
    check("post_result", wb_view.result, 32'h0000_7FFF);
    step();
    data_sram_data_ok = 1'b0;
    #1;
    check("post_gone", mem_wb_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
